// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Types and constants shared by the MIPS pipeline blocks.
//   pcsrc_t      : PC source select driven by pipeline_control into the PC mux
//                  (PC4 = sequential, JUMP = ID-stage jump target,
//                  BRANCH = MEM-stage branch target).
//   pctl_state_t : sequencing state of pipeline_control.
//   REG_ZERO     : architectural $zero, which never creates a dependency.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PC4    = 2'd0,
    JUMP   = 2'd1,
    BRANCH = 2'd2
  } pcsrc_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pctl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator.
// Inputs : exDRE  - EX-stage instruction is a load
//          ex_rt  - destination register of that load
//          id_rs  - rs field of the ID-stage instruction
//          id_rt  - rt field of the ID-stage instruction
// Output : luse   - ID-stage instruction needs the loaded value before
//                   it can be forwarded, so one bubble is required
// ---------------------------------------------------------------------------
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic       exDRE,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       luse
);

  // A load into $zero is discarded by the register file, so it never
  // causes a dependency even if the ID instruction names $zero.
  assign luse = exDRE && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_control.sv
// ---------------------------------------------------------------------------
// pipeline_control
// Hazard and sequencing controller for the five-stage MIPS pipeline.
// Produces write enables / flushes for the PC and the four pipeline
// registers, selects the PC source, sequences HALT and counts stall cycles.
// Inputs : CLK, nRST (async, active-low)
//          ihit, dhit            - I-cache / D-cache handshakes
//          memDRE, memDWE        - MEM-stage data access
//          exDRE, ex_rt          - EX-stage load and its destination
//          id_rs, id_rt, id_jump - ID-stage sources and jump redirect
//          mem_br_taken          - branch resolved taken in MEM
//          mem_halt              - HALT is in MEM
// Outputs: pcW, ifidW, idexW, exmemW, memwbW  - register write enables
//          ifidFlush, idexFlush, exmemFlush   - bubble insertion
//          redirect_sel                       - PC source (pcsrc_t)
//          halt                               - pipeline halted (registered)
//          stall_cnt                          - saturating stall-cycle count
// ---------------------------------------------------------------------------
module pipeline_control
  import cpu_types_pkg::*;
#(
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            memDRE,
  input  logic            memDWE,
  input  logic            exDRE,
  input  logic [4:0]      ex_rt,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            id_jump,
  input  logic            mem_br_taken,
  input  logic            mem_halt,
  output logic            pcW,
  output logic            ifidW,
  output logic            idexW,
  output logic            exmemW,
  output logic            memwbW,
  output logic            ifidFlush,
  output logic            idexFlush,
  output logic            exmemFlush,
  output logic [1:0]      redirect_sel,
  output logic            halt,
  output logic [CNTW-1:0] stall_cnt
);

  pctl_state_t     st_q, st_d;
  logic            br_pend_q, br_pend_d;
  logic            halt_q, halt_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  pcsrc_t          redirect;
  logic            luse;
  logic            dwait;
  logic            br_active;

  hazard_detect u_hazard_detect (
    .exDRE (exDRE),
    .ex_rt (ex_rt),
    .id_rs (id_rs),
    .id_rt (id_rt),
    .luse  (luse)
  );

  assign dwait     = (memDRE || memDWE) && !dhit;
  assign br_active = mem_br_taken || br_pend_q;

  // Next-state and output priority encoder.
  always_comb begin
    pcW        = 1'b1;
    ifidW      = 1'b1;
    idexW      = 1'b1;
    exmemW     = 1'b1;
    memwbW     = 1'b1;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    redirect   = PC4;
    st_d       = st_q;
    br_pend_d  = br_pend_q;
    halt_d     = halt_q;

    if (st_q == HALTED) begin
      pcW       = 1'b0;
      ifidW     = 1'b0;
      idexW     = 1'b0;
      exmemW    = 1'b0;
      memwbW    = 1'b0;
      br_pend_d = 1'b0;
    end else if (st_q == DRAIN) begin
      // HALT is in WB this cycle; keep filling the front with bubbles.
      pcW        = 1'b0;
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      exmemFlush = 1'b1;
      st_d       = HALTED;
      halt_d     = 1'b1;
    end else if (dwait) begin
      // Whole pipe freezes; a pending redirect is kept for the dhit cycle.
      pcW    = 1'b0;
      ifidW  = 1'b0;
      idexW  = 1'b0;
      exmemW = 1'b0;
      memwbW = 1'b0;
      st_d   = DWAIT;
    end else if (mem_halt) begin
      // HALT moves to WB while everything younger is squashed.
      pcW        = 1'b0;
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
      exmemFlush = 1'b1;
      st_d       = DRAIN;
      br_pend_d  = 1'b0;
    end else begin
      st_d = RUN;
      if (br_active) begin
        // The branch squashes the ID instruction, so any load-use
        // stall against it is irrelevant.
        redirect   = BRANCH;
        pcW        = ihit;
        ifidW      = ihit;
        ifidFlush  = 1'b1;
        idexFlush  = 1'b1;
        exmemFlush = 1'b1;
        br_pend_d  = !ihit;
      end else if (luse) begin
        pcW       = 1'b0;
        ifidW     = 1'b0;
        idexFlush = 1'b1;
      end else if (id_jump) begin
        redirect  = JUMP;
        pcW       = ihit;
        ifidW     = ihit;
        ifidFlush = 1'b1;
      end else if (!ihit) begin
        pcW       = 1'b0;
        ifidW     = 1'b0;
        idexFlush = 1'b1;
      end
    end
  end

  // Stall counter: cycles with the PC held, excluding the halted state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pcW && (st_q != HALTED) && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_q        <= RUN;
      br_pend_q   <= 1'b0;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      br_pend_q   <= br_pend_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign redirect_sel = redirect;
  assign halt         = halt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// ---------------------------------------------------------------------------
// tb_pipeline_control
// Directed self-checking bench for pipeline_control. Inputs change 1 time
// unit after a rising edge and outputs are compared 1 unit later.
// ---------------------------------------------------------------------------
module tb_pipeline_control;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, memDRE, memDWE, exDRE;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        id_jump, mem_br_taken, mem_halt;
  logic        pcW, ifidW, idexW, exmemW, memwbW;
  logic        ifidFlush, idexFlush, exmemFlush;
  logic [1:0]  redirect_sel;
  logic        halt;
  logic [31:0] stall_cnt;
  logic [4:0]  wvec;
  logic [2:0]  fvec;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipeline_control #(.CNTW(32)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .memDRE       (memDRE),
    .memDWE       (memDWE),
    .exDRE        (exDRE),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_jump      (id_jump),
    .mem_br_taken (mem_br_taken),
    .mem_halt     (mem_halt),
    .pcW          (pcW),
    .ifidW        (ifidW),
    .idexW        (idexW),
    .exmemW       (exmemW),
    .memwbW       (memwbW),
    .ifidFlush    (ifidFlush),
    .idexFlush    (idexFlush),
    .exmemFlush   (exmemFlush),
    .redirect_sel (redirect_sel),
    .halt         (halt),
    .stall_cnt    (stall_cnt)
  );

  assign wvec = {pcW, ifidW, idexW, exmemW, memwbW};
  assign fvec = {ifidFlush, idexFlush, exmemFlush};

  // Drive one cycle's worth of inputs and let the outputs settle.
  task automatic applyStimulus(
    input logic       v_ihit,
    input logic       v_dhit,
    input logic       v_memDRE,
    input logic       v_memDWE,
    input logic       v_exDRE,
    input logic [4:0] v_ex_rt,
    input logic [4:0] v_id_rs,
    input logic [4:0] v_id_rt,
    input logic       v_jump,
    input logic       v_br,
    input logic       v_halt
  );
    ihit         = v_ihit;
    dhit         = v_dhit;
    memDRE       = v_memDRE;
    memDWE       = v_memDWE;
    exDRE        = v_exDRE;
    ex_rt        = v_ex_rt;
    id_rs        = v_id_rs;
    id_rt        = v_id_rt;
    id_jump      = v_jump;
    mem_br_taken = v_br;
    mem_halt     = v_halt;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic resetDut();
    nRST = 1'b0;
    applyIdle();
    @(negedge CLK);
    nRST = 1'b1;
    stepCycle();
  endtask

  initial begin
    nRST = 1'b0;
    applyIdle();
    #2;
    checkOutput("rst_W", 32'(wvec), 32'h1f);
    checkOutput("rst_flush", 32'(fvec), 32'h0);
    checkOutput("rst_halt", 32'(halt), 32'h0);
    checkOutput("rst_cnt", stall_cnt, 32'd0);
    checkOutput("rst_st", 32'(dut.st_q), 32'(RUN));
    @(negedge CLK);
    nRST = 1'b1;
    stepCycle();

    // Load-use on rs: one bubble.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs_W", 32'(wvec), 32'h07);
    checkOutput("lu_rs_flush", 32'(fvec), 32'h2);
    stepCycle();
    applyIdle();
    checkOutput("lu_after_W", 32'(wvec), 32'h1f);
    checkOutput("lu_cnt", stall_cnt, 32'd1);

    // Load-use on rt.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rt_W", 32'(wvec), 32'h07);
    stepCycle();
    applyIdle();
    checkOutput("lu_rt_cnt", stall_cnt, 32'd2);

    // Load into $zero never stalls.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("zero_W", 32'(wvec), 32'h1f);
    checkOutput("zero_flush", 32'(fvec), 32'h0);
    stepCycle();

    // Data miss for four cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("dmiss_W%0d", i), 32'(wvec), 32'h0);
      stepCycle();
      checkOutput($sformatf("dmiss_st%0d", i), 32'(dut.st_q), 32'(DWAIT));
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("dhit_W", 32'(wvec), 32'h1f);
    stepCycle();
    checkOutput("dhit_st", 32'(dut.st_q), 32'(RUN));
    checkOutput("dmiss_cnt", stall_cnt, 32'd6);

    // Branch taken while fetch misses for two cycles.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("br0_sel", 32'(redirect_sel), 32'd2);
    checkOutput("br0_W", 32'(wvec), 32'h07);
    checkOutput("br0_flush", 32'(fvec), 32'h7);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("br1_pend", 32'(dut.br_pend_q), 32'd1);
    checkOutput("br1_sel", 32'(redirect_sel), 32'd2);
    checkOutput("br1_flush", 32'(fvec), 32'h7);
    stepCycle();
    applyIdle();
    checkOutput("br2_sel", 32'(redirect_sel), 32'd2);
    checkOutput("br2_W", 32'(wvec), 32'h1f);
    checkOutput("br2_flush", 32'(fvec), 32'h7);
    stepCycle();
    applyIdle();
    checkOutput("br3_pend", 32'(dut.br_pend_q), 32'd0);
    checkOutput("br3_sel", 32'(redirect_sel), 32'd0);
    checkOutput("br3_cnt", stall_cnt, 32'd8);

    // Branch and load-use together: branch wins.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("brlu_W", 32'(wvec), 32'h1f);
    checkOutput("brlu_flush", 32'(fvec), 32'h7);
    checkOutput("brlu_sel", 32'(redirect_sel), 32'd2);
    stepCycle();

    // Jump in ID, then a plain fetch miss.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("jmp_sel", 32'(redirect_sel), 32'd1);
    checkOutput("jmp_W", 32'(wvec), 32'h1f);
    checkOutput("jmp_flush", 32'(fvec), 32'h4);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("imiss_W", 32'(wvec), 32'h07);
    checkOutput("imiss_flush", 32'(fvec), 32'h2);
    checkOutput("imiss_sel", 32'(redirect_sel), 32'd0);
    stepCycle();

    // Data wait beats branch; redirect lands on the dhit cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("dwbr_W", 32'(wvec), 32'h0);
    checkOutput("dwbr_flush", 32'(fvec), 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("dwbr_hit_sel", 32'(redirect_sel), 32'd2);
    checkOutput("dwbr_hit_W", 32'(wvec), 32'h1f);
    stepCycle();
    applyIdle();
    checkOutput("dwbr_cnt", stall_cnt, 32'd10);

    // Halt: DRAIN then HALTED.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("hlt0_W", 32'(wvec), 32'h0f);
    checkOutput("hlt0_flush", 32'(fvec), 32'h7);
    stepCycle();
    applyIdle();
    checkOutput("hlt1_st", 32'(dut.st_q), 32'(DRAIN));
    checkOutput("hlt1_halt", 32'(halt), 32'd0);
    checkOutput("hlt1_W", 32'(wvec), 32'h0f);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("hlt2_st", 32'(dut.st_q), 32'(HALTED));
    checkOutput("hlt2_halt", 32'(halt), 32'd1);
    checkOutput("hlt2_W", 32'(wvec), 32'h0);
    checkOutput("hlt2_flush", 32'(fvec), 32'h0);
    checkOutput("hlt2_sel", 32'(redirect_sel), 32'd0);
    stepCycle();
    stepCycle();
    checkOutput("hlt4_halt", 32'(halt), 32'd1);
    checkOutput("hlt4_W", 32'(wvec), 32'h0);
    checkOutput("hlt4_cnt", stall_cnt, 32'd12);

    // Reset out of HALTED, then halt behind a pending data write.
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("hdw_W", 32'(wvec), 32'h0);
    stepCycle();
    checkOutput("hdw_st", 32'(dut.st_q), 32'(DWAIT));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("hdw_hit_W", 32'(wvec), 32'h0f);
    stepCycle();
    applyIdle();
    checkOutput("hdw_drain_halt", 32'(halt), 32'd0);
    stepCycle();
    checkOutput("hdw_halt", 32'(halt), 32'd1);

    // Reset asserted mid-DRAIN.
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    stepCycle();
    applyIdle();
    checkOutput("mrst_pre_st", 32'(dut.st_q), 32'(DRAIN));
    nRST = 1'b0;
    #1;
    checkOutput("mrst_st", 32'(dut.st_q), 32'(RUN));
    checkOutput("mrst_halt", 32'(halt), 32'd0);
    checkOutput("mrst_cnt", stall_cnt, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    stepCycle();
    checkOutput("mrst_post_st", 32'(dut.st_q), 32'(RUN));
    checkOutput("mrst_post_W", 32'(wvec), 32'h1f);
    checkOutput("mrst_post_cnt", stall_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
